// File: rtl/omsp_atomicity_guard_pkg.sv
// Shared types for the openMSP430 atomicity guard: section states and the
// sticky violation cause codes reported to software.
package omsp_atomicity_guard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CLIX  = 2'b01,
        ST_ENTRY = 2'b10
    } atom_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'b00,
        CAUSE_NEST_CLIX  = 2'b01,
        CAUSE_BOUND      = 2'b10,
        CAUSE_NEST_ENTRY = 2'b11
    } viol_cause_e;

endpackage

// File: rtl/omsp_sat_counter.sv
// Up-counter with synchronous clear that sticks at its all-ones value
// instead of wrapping.
module omsp_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/omsp_atomicity_guard.sv
// Keeps interrupts masked during clix sections and the post-entry window of a
// protected module, flags misuse, and records how long IRQs were held off.
module omsp_atomicity_guard
    import omsp_atomicity_guard_pkg::*;
#(
    parameter int ATOM_BOUND   = 10,
    parameter int ENTRY_PERIOD = 8,
    parameter bit RESTRICT_GIE = 1'b0,
    parameter int DEFER_W      = 8
) (
    input  logic               mclk,
    input  logic               puc_rst,
    input  logic               inst_clix,
    input  logic [15:0]        clix_len,
    input  logic               enter_sm,
    input  logic               sm_executing,
    input  logic               priv_mode,
    input  logic               r2_gie,
    input  logic               irq_detect,
    input  logic               stat_clr,
    output logic               gie,
    output logic               atom_violation,
    output logic [1:0]         viol_cause,
    output logic               irq_deferred,
    output logic [DEFER_W-1:0] max_defer
);

    localparam int CNT_MAX = (ATOM_BOUND > ENTRY_PERIOD) ? ATOM_BOUND : ENTRY_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    atom_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    viol_cause_e        viol_cause_q, viol_cause_d;
    viol_cause_e        viol_code;
    logic               irq_deferred_q, irq_deferred_d;
    logic [DEFER_W-1:0] max_defer_q, max_defer_d;
    logic [DEFER_W-1:0] defer_count;
    logic               clix_finished;
    logic               priv_entry;

    assign clix_finished = (cnt_q == '0) | r2_gie;
    assign priv_entry    = RESTRICT_GIE & priv_mode;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        viol_code = CAUSE_NONE;
        if (enter_sm) begin
            if (priv_entry) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else if (state_q == ST_ENTRY) begin
                viol_code = CAUSE_NEST_ENTRY;
                state_d   = ST_IDLE;
                cnt_d     = '0;
            end else begin
                state_d = ST_ENTRY;
                cnt_d   = CNT_W'(ENTRY_PERIOD);
            end
        end else if (inst_clix) begin
            // The bound test uses all 16 bits so a huge length cannot alias into range.
            if (clix_len > 16'(ATOM_BOUND)) begin
                viol_code = CAUSE_BOUND;
            end else if (state_q == ST_CLIX) begin
                viol_code = CAUSE_NEST_CLIX;
            end else begin
                state_d = ST_CLIX;
                cnt_d   = clix_len[CNT_W-1:0];
            end
        end else begin
            case (state_q)
                ST_CLIX: begin
                    if (clix_finished) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_ENTRY: begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        viol_cause_d = viol_cause_q;
        if (stat_clr) begin
            viol_cause_d = CAUSE_NONE;
        end else if ((viol_cause_q == CAUSE_NONE) && (viol_code != CAUSE_NONE)) begin
            viol_cause_d = viol_code;
        end

        irq_deferred_d = (state_d != ST_IDLE) &
                         (irq_deferred_q | (irq_detect & (state_q != ST_IDLE)));

        // The run length is folded into the maximum once the deferral has ended.
        max_defer_d = max_defer_q;
        if (stat_clr) begin
            max_defer_d = '0;
        end else if (!irq_deferred_q && (defer_count > max_defer_q)) begin
            max_defer_d = defer_count;
        end
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            viol_cause_q   <= CAUSE_NONE;
            irq_deferred_q <= 1'b0;
            max_defer_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            viol_cause_q   <= viol_cause_d;
            irq_deferred_q <= irq_deferred_d;
            max_defer_q    <= max_defer_d;
        end
    end

    omsp_sat_counter #(
        .W (DEFER_W)
    ) u_defer_cnt (
        .clk   (mclk),
        .rst   (puc_rst),
        .clr   (stat_clr | ~irq_deferred_q),
        .inc   (irq_deferred_q),
        .count (defer_count)
    );

    assign gie = r2_gie & ~inst_clix & ~enter_sm &
                 ((state_q == ST_IDLE) | ((state_q == ST_CLIX) & clix_finished)) &
                 ~(priv_entry & sm_executing);

    assign atom_violation = (viol_code != CAUSE_NONE) & ~puc_rst;
    assign viol_cause     = viol_cause_q;
    assign irq_deferred   = irq_deferred_q;
    assign max_defer      = max_defer_q;

endmodule
